// File: rtl/axi_fifo_pkg.sv
// Shared defaults and pointer-width helper for the native/AXIS FIFO slice.
package axi_fifo_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_fifo_core.sv
// AXI-Stream FIFO core: memory, wrapping pointers and occupancy count.
// Latency: a word accepted at edge N is offered on m_axis from edge N (FWFT).
// Backpressure: s_axis_tready drops while DEPTH words are held; m_axis_tvalid drops when empty.
module axis_fifo_core
    import axi_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    assign s_axis_tready = (count != FULL_CNT);
    assign m_axis_tvalid = (count != '0);
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tready & m_axis_tvalid;
    assign m_axis_tdata  = mem[rd_ptr];

    // Storage is deliberately left out of reset; the count alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_fifo_to_native_fifo.sv
// Native (wr_en/full, rd_en/empty) FIFO built on the AXIS core; dout forced to 0 when empty.
// Latency: one cycle write-to-read, first-word-fall-through on dout.
// Backpressure: writes dropped while full; reads ignored while empty.
module axi_fifo_to_native_fifo
    import axi_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] dout
);

    logic              s_tready;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;

    axis_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk           (clk),
        .srst          (srst),
        .s_axis_tvalid (wr_en),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (din),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (rd_en),
        .m_axis_tdata  (m_tdata)
    );

    assign full  = ~s_tready;
    assign empty = ~m_tvalid;
    // Stale memory must never leak out while nothing valid is held.
    assign dout  = empty ? '0 : m_tdata;

endmodule

// File: tb/tb_axi_fifo_to_native_fifo.sv
// Self-checking bench: vector table, directed corner sequences and a queue-based random model.
module tb_axi_fifo_to_native_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 32;

    logic              clk   = 1'b0;
    logic              srst  = 1'b1;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] din   = '0;
    logic              empty;
    logic              full;
    logic [DATA_W-1:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] q[$];

    typedef struct {
        logic              wr;
        logic              rd;
        logic [DATA_W-1:0] d;
        logic              e_empty;
        logic              e_full;
        logic [DATA_W-1:0] e_dout;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    axi_fifo_to_native_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .srst  (srst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din),
        .empty (empty),
        .full  (full),
        .dout  (dout)
    );

    task automatic cmp(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one clock of stimulus and advances the queue model by the FIFO rules.
    task automatic cycle(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        bit do_pop;
        bit do_push;
        wr_en   = wr;
        rd_en   = rd;
        din     = d;
        do_pop  = rd && (q.size() != 0);
        do_push = wr && (q.size() != DEPTH);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_model(input string name);
        logic [DATA_W-1:0] exp_dout;
        exp_dout = (q.size() == 0) ? '0 : q[0];
        cmp({name, " empty"}, empty, (q.size() == 0));
        cmp({name, " full"}, full, (q.size() == DEPTH));
        cmp({name, " dout"}, dout, exp_dout);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: asynchronous assert, observed without any clock edge.
        #1 srst = 1'b0;
        #0.5;
        cmp("reset empty", empty, 1);
        cmp("reset full", full, 0);
        cmp("reset dout", dout, 0);
        #0.5 srst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 64'hDEAD);
            check_model("idle");
        end

        // Vector table: simultaneous write/read on empty and small occupancy patterns.
        tbl[0] = '{1'b1, 1'b1, 64'd5, 1'b0, 1'b0, 64'd5};
        tbl[1] = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 64'd0};
        tbl[2] = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 64'd0};
        tbl[3] = '{1'b1, 1'b0, 64'd7, 1'b0, 1'b0, 64'd7};
        tbl[4] = '{1'b1, 1'b0, 64'd8, 1'b0, 1'b0, 64'd7};
        tbl[5] = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 64'd8};
        tbl[6] = '{1'b1, 1'b1, 64'd9, 1'b0, 1'b0, 64'd9};
        tbl[7] = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 64'd0};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].wr, tbl[i].rd, tbl[i].d);
            cmp($sformatf("vec%0d empty", i), empty, tbl[i].e_empty);
            cmp($sformatf("vec%0d full", i), full, tbl[i].e_full);
            cmp($sformatf("vec%0d dout", i), dout, tbl[i].e_dout);
        end

        // Streaming: 20 words in flight, then continuous write+read.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, DATA_W'(i));
        for (int i = 20; i < 60; i++) begin
            cmp("stream dout", dout, DATA_W'(i - 20));
            cmp("stream full", full, 0);
            cycle(1'b1, 1'b1, DATA_W'(i));
            cmp("stream empty", empty, 0);
        end
        for (int i = 0; i < 40 && !empty; i++) begin
            cycle(1'b0, 1'b1, '0);
            check_model("stream drain");
        end
        cmp("stream drained", empty, 1);

        // Fill to full, drop an overflow write, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            cmp("fill not full", full, 0);
            cycle(1'b1, 1'b0, DATA_W'(i));
        end
        cmp("fill full", full, 1);
        cycle(1'b1, 1'b0, 64'd99);
        cmp("overflow full", full, 1);
        cmp("overflow head", dout, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cmp("fill read", dout, DATA_W'(i));
            cycle(1'b0, 1'b1, '0);
        end
        cmp("fill drained empty", empty, 1);
        cmp("fill drained dout", dout, 0);

        // Full FIFO with write and read together: pop happens, write dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DATA_W'(i));
        cycle(1'b1, 1'b1, 64'd77);
        cmp("fullsim full", full, 0);
        cmp("fullsim empty", empty, 0);
        cmp("fullsim dout", dout, 1);
        for (int i = 1; i < DEPTH; i++) begin
            cmp("fullsim read", dout, DATA_W'(i));
            cycle(1'b0, 1'b1, '0);
        end
        cmp("fullsim drained", empty, 1);

        // Pointer wrap with single-word round trips.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, DATA_W'(1000 + i));
            cmp("wrap dout", dout, DATA_W'(1000 + i));
            cycle(1'b0, 1'b1, '0);
            cmp("wrap empty", empty, 1);
        end

        // Asynchronous reset mid-operation with 10 words held.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DATA_W'(200 + i));
        cmp("prereset empty", empty, 0);
        #2 srst = 1'b0;
        #1;
        cmp("async reset empty", empty, 1);
        cmp("async reset full", full, 0);
        cmp("async reset dout", dout, 0);
        q.delete();
        @(posedge clk);
        #1 srst = 1'b1;
        check_model("post reset");
        cycle(1'b1, 1'b0, 64'd55);
        cmp("post reset write", dout, 55);
        cycle(1'b0, 1'b1, '0);
        check_model("post reset read");

        // Randomized traffic alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            int  wr_pct;
            int  rd_pct;
            logic wr;
            logic rd;
            wr_pct = ((i / 200) % 2 == 0) ? 80 : 30;
            rd_pct = ((i / 200) % 2 == 0) ? 30 : 80;
            wr = ($urandom_range(0, 99) < wr_pct);
            rd = ($urandom_range(0, 99) < rd_pct);
            cycle(wr, rd, {$urandom, $urandom});
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
